// File: rtl/ascon_round_scheduler.sv
// Ascon round scheduler: walks the one-round serial permutation datapath through
// a full p^12 / p^8 / p^6 permutation. One start pulse goes out per round, and the
// serial round-constant bit is streamed during the 64-cycle constant pass. The
// scheduler then waits for the datapath's round-complete pulse.
module ascon_round_scheduler #(
  parameter int WORD_BITS  = 64,
  parameter int MAX_ROUNDS = 12,
  localparam int BIT_W     = $clog2(WORD_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       rounds_sel,
  input  logic             abort,
  input  logic             round_done,
  output logic             start_permutation,
  output logic             constant,
  output logic             busy,
  output logic             done,
  output logic [3:0]       round_idx,
  output logic [BIT_W-1:0] bit_idx,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CONST,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WORD_BITS - 1);
  // The 8-bit round constant occupies the last byte of the serial pass.
  localparam logic [BIT_W-1:0] BIT_CONST0 = BIT_W'(WORD_BITS - 8);
  localparam logic [3:0]       ROUND_LAST = 4'(MAX_ROUNDS - 1);

  state_t           state_q, state_d;
  logic [3:0]       round_idx_q, round_idx_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic             err_q, err_d;
  logic [3:0]       first_round;
  logic [7:0]       rc;

  assign round_idx = round_idx_q;
  assign bit_idx   = bit_idx_q;
  assign err       = err_q;

  // Round constant c(r) = {F - r, r}.
  // The datapath expects it MSB first, so bit k of the pass selects rc[7 - k%8].
  assign rc = {4'hF - round_idx_q, round_idx_q};

  // Map the round-count selection to the first absolute round in the constant table.
  always_comb begin
    first_round = 4'd0;
    case (rounds_sel)
      2'b01:   first_round = 4'd4;
      2'b10:   first_round = 4'd6;
      default: first_round = 4'd0;
    endcase
  end

  // Next-state, counter updates and decoded outputs; abort overrides normal sequencing.
  always_comb begin
    state_d           = state_q;
    round_idx_d       = round_idx_q;
    bit_idx_d         = bit_idx_q;
    err_d             = err_q;
    start_permutation = 1'b0;
    constant          = 1'b0;
    busy              = 1'b1;
    done              = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          state_d     = S_ISSUE;
          round_idx_d = first_round;
          err_d       = 1'b0;
        end
      end
      S_ISSUE: begin
        start_permutation = 1'b1;
        bit_idx_d         = '0;
        state_d           = S_CONST;
      end
      S_CONST: begin
        if (bit_idx_q >= BIT_CONST0) begin
          constant = rc[~bit_idx_q[2:0]];
        end
        if (bit_idx_q == BIT_LAST) begin
          state_d = S_WAIT;
        end else begin
          bit_idx_d = bit_idx_q + BIT_W'(1);
        end
      end
      S_WAIT: begin
        if (round_done) begin
          if (round_idx_q == ROUND_LAST) begin
            state_d = S_DONE;
          end else begin
            round_idx_d = round_idx_q + 4'd1;
            state_d     = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A completion pulse is only legal while waiting on the datapath.
    if (round_done && (state_q != S_WAIT)) begin
      err_d = 1'b1;
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      round_idx_d = '0;
      bit_idx_d   = '0;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      round_idx_q <= '0;
      bit_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      bit_idx_q   <= bit_idx_d;
      err_q       <= err_d;
    end
  end

endmodule
